// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared core memory bus: data port wins by default,
// instruction fetch is force-granted after MAX_WAIT lost arbitration cycles.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_data,
  input  logic                  d_valid,
  input  logic                  d_is_write,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2:0]            d_size,
  input  logic [DATA_W/8-1:0]   d_strobe,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  c_valid,
  output logic                  c_is_write,
  output logic [ADDR_W-1:0]     c_addr,
  output logic [2:0]            c_size,
  output logic [DATA_W/8-1:0]   c_strobe,
  output logic [DATA_W-1:0]     c_wdata,
  input  logic                  c_ready,
  input  logic                  c_last,
  input  logic [DATA_W-1:0]     c_rdata,
  output logic                  abort_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       starve;
  logic       done;

  assign starve = (wait_cnt_q >= MAX_WAIT_C) && i_valid;
  assign done   = c_ready && c_last;

  // Next-state, bus routing and anti-starvation counter update.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    c_valid    = 1'b0;
    c_is_write = 1'b0;
    c_addr     = '0;
    c_size     = 3'b000;
    c_strobe   = '0;
    c_wdata    = '0;
    i_ready    = 1'b0;
    i_data     = '0;
    d_ready    = 1'b0;
    d_rdata    = '0;
    abort_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_valid && !starve) begin
          state_d = GRANT_D;
        end else if (i_valid) begin
          state_d = GRANT_I;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I: begin
        c_valid = i_valid;
        c_addr  = i_addr;
        c_size  = 3'b011;
        i_data  = c_rdata;
        // A final beat completes the transaction even if valid fell with it.
        if (i_valid || done) begin
          i_ready = c_ready;
          state_d = done ? IDLE : GRANT_I;
        end else begin
          abort_err = 1'b1;
          state_d   = IDLE;
        end
      end
      GRANT_D: begin
        c_valid    = d_valid;
        c_is_write = d_is_write;
        c_addr     = d_addr;
        c_size     = d_size;
        c_strobe   = d_strobe;
        c_wdata    = d_wdata;
        d_rdata    = c_rdata;
        if (d_valid || done) begin
          d_ready = c_ready;
          state_d = done ? IDLE : GRANT_D;
        end else begin
          abort_err = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counts cycles a pending fetch spends behind the data port.
    if (!i_valid) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == IDLE) && (state_d == GRANT_I)) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == GRANT_D) || ((state_q == IDLE) && (state_d == GRANT_D))) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : (wait_cnt_q + 8'd1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State and counter registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
